// File: rtl/mant_mul_iter.sv
// Iterative unsigned mantissa multiplier. One 8x8 digit product is formed per cycle,
// shifted into place and accumulated, giving a 2W-bit product after DIGITS^2 cycles.

module v8x8 (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);
  assign p = 16'(x) * 16'(y);
endmodule

module mant_mul_iter #(
  parameter int DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DIGITS-1:0]     a,
  input  logic [8*DIGITS-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*DIGITS-1:0]    product
);
  localparam int W  = 8 * DIGITS;
  localparam int PW = 2 * W;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [7:0]      x_dig, y_dig;
  logic [15:0]     p16;
  logic [IW:0]     dsum;
  logic [IW+3:0]   shamt;
  logic [PW-1:0]   term;
  logic [PW-1:0]   acc_sum;

  assign x_dig = a_q[{i_q, 3'b000} +: 8];
  assign y_dig = b_q[{j_q, 3'b000} +: 8];

  v8x8 u_v8x8 (
    .x (x_dig),
    .y (y_dig),
    .p (p16)
  );

  // Digit pair (i,j) carries weight 2^(8*(i+j)); the sum can never exceed 2W bits.
  assign dsum    = {1'b0, i_q} + {1'b0, j_q};
  assign shamt   = {dsum, 3'b000};
  assign term    = PW'(p16) << shamt;
  assign acc_sum = acc_q + term;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves a variable unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    i_d         = i_q;
    j_d         = j_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            product_d   = acc_sum;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        // The cycle spent returning to IDLE keeps input and output handshakes apart.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      i_q         <= i_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mant_mul_iter.sv
// Scoreboard bench for mant_mul_iter: the driver queues expected products, a monitor
// pops and compares them on every output handshake and also checks latency and spacing.

module tb_mant_mul_iter;
  localparam int DIGITS  = 7;
  localparam int W       = 8 * DIGITS;
  localparam int PW      = 2 * W;
  localparam int LAT     = DIGITS * DIGITS;
  localparam int II      = DIGITS * DIGITS + 2;
  localparam int NRAND   = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] product;

  mant_mul_iter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [PW-1:0] exp_q[$];
  int            acc_t[$];
  bit            busy = 1'b0;
  int            busy_ready_cnt = 0;
  bit            prev_ov = 1'b0;
  bit            b2b = 1'b0;
  bit            b2b_first = 1'b0;
  int            last_acc = 0;
  int            n_delivered = 0;

  task automatic check(input string name, input logic [PW-1:0] actual,
                       input logic [PW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy           = 1'b0;
      busy_ready_cnt = 0;
      prev_ov        = 1'b0;
      acc_t.delete();
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_t.size() == 0)
          check("unexpected_out_valid", PW'(1), PW'(0));
        else
          check("latency", PW'(cyc - acc_t.pop_front()), PW'(LAT));
      end
      if (out_valid && out_ready) begin
        if (busy && in_ready) busy_ready_cnt++;
        check("in_ready_low_while_busy", PW'(busy_ready_cnt), PW'(0));
        busy_ready_cnt = 0;
        busy = 1'b0;
        if (exp_q.size() == 0)
          check("unexpected_product", PW'(1), PW'(0));
        else
          check("product", product, exp_q.pop_front());
        n_delivered++;
      end else if (busy && in_ready) begin
        busy_ready_cnt++;
      end
      if (in_valid && in_ready) begin
        if (b2b && !b2b_first)
          check("accept_spacing", PW'(cyc + 1 - last_acc), PW'(II));
        b2b_first = 1'b0;
        last_acc  = cyc + 1;
        acc_t.push_back(cyc + 1);
        busy = 1'b1;
      end
      prev_ov = out_valid;
    end
  end

  // Presents one operand pair until accepted, then queues its expected product.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [PW-1:0] ev, input bit drop_valid);
    bit ok = 1'b0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int k = 0; k < 4 * II; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", PW'(0), PW'(1));
    end else begin
      exp_q.push_back(ev);
    end
    @(posedge clk);
    #1;
    if (drop_valid) begin
      in_valid = 1'b0;
      // Operands change during RUN and must have no effect.
      a = {W{1'b1}} ^ av;
      b = {W{1'b1}} ^ bv;
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 4 * II; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", PW'(0), PW'(1));
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0]  va[8];
  logic [W-1:0]  vb[8];
  logic [PW-1:0] ve[8];

  initial begin
    logic [PW-1:0] p0;
    logic [63:0]   r;
    int            changes;
    bit            seen;

    va[0] = 56'h3;              vb[0] = 56'h5;              ve[0] = 112'hF;
    va[1] = 56'hFF;             vb[1] = 56'hFF;             ve[1] = 112'hFE01;
    va[2] = 56'h100;            vb[2] = 56'h100;            ve[2] = 112'h10000;
    va[3] = 56'hFFFFFFFFFFFFFF; vb[3] = 56'h1;              ve[3] = 112'hFFFFFFFFFFFFFF;
    va[4] = 56'hFFFFFFFFFFFFFF; vb[4] = 56'h2;              ve[4] = 112'h1FFFFFFFFFFFFFE;
    va[5] = 56'h80000000000000; vb[5] = 56'h80000000000000; ve[5] = 112'h1 << 110;
    va[6] = 56'h01000000000000; vb[6] = 56'hFF;             ve[6] = 112'hFF000000000000;
    va[7] = 56'h12345;          vb[7] = 56'h10;             ve[7] = 112'h123450;

    // Reset state.
    #12;
    check("reset_in_ready", PW'(in_ready), PW'(1));
    check("reset_out_valid", PW'(out_valid), PW'(0));
    check("reset_product", product, PW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero operand against all-ones.
    issue(56'h0, 56'hFFFFFFFFFFFFFF, PW'(0), 1'b1);
    wait_drain();

    // 1.0 x 1.0 mantissas.
    issue(56'h10000000000000, 56'h10000000000000, 112'h1 << 104, 1'b1);
    wait_drain();

    // Largest operands: top digit pair must not be truncated.
    issue(56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF, 112'hFFFFFFFFFFFFFE00000000000001, 1'b1);
    wait_drain();

    // Output stall with a reference-model product.
    out_ready = 1'b0;
    issue(56'h123456789ABCDE, 56'h0FEDCBA9876543,
          PW'(56'h123456789ABCDE) * PW'(56'h0FEDCBA9876543), 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_out_valid_seen", PW'(seen), PW'(1));
    p0 = product;
    changes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (product !== p0 || !out_valid) changes++;
    end
    check("stall_product_stable", PW'(changes), PW'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_drops", PW'(out_valid), PW'(0));
    check("in_ready_returns", PW'(in_ready), PW'(1));
    wait_drain();

    // Reset in the middle of RUN discards the partial result.
    issue(56'hABCDEF01234567, 56'h76543210FEDCBA, PW'(0), 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_out_valid", PW'(out_valid), PW'(0));
    check("midrun_reset_in_ready", PW'(in_ready), PW'(1));
    check("midrun_reset_product", product, PW'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(56'h3, 56'h5, PW'(15), 1'b1);
    wait_drain();

    // Back-to-back operations with in_valid held high throughout.
    b2b = 1'b1;
    b2b_first = 1'b1;
    for (int k = 0; k < 8; k++) issue(va[k], vb[k], ve[k], 1'b0);
    for (int k = 0; k < NRAND; k++) begin
      logic [W-1:0] ra, rb;
      r  = {$urandom(), $urandom()};
      ra = r[W-1:0];
      r  = {$urandom(), $urandom()};
      rb = r[W-1:0];
      issue(ra, rb, PW'(ra) * PW'(rb), 1'b0);
    end
    in_valid = 1'b0;
    wait_drain();
    b2b = 1'b0;

    check("delivered_count", PW'(n_delivered), PW'(5 + 8 + NRAND));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
